// File: rtl/fifo_wr_framer.sv
`default_nettype none
// ============================================================================
// fifo_wr_framer : frames a valid/ready beat stream into FIFO words, appending
//                  a count/err trailer per frame and truncating long frames.
// Revision 1.0
// ============================================================================
module fifo_wr_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  Wclk,
  input  logic                  Wrstb,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATA_WIDTH-1:0] InData,
  input  logic                  InLast,
  input  logic                  Full,
  output logic                  Wen,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [15:0]           FrameCnt,
  output logic [15:0]           TruncCnt
);

  localparam int CNT_WIDTH = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BEATS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BODY    = 2'd1,
    TRAILER = 2'd2,
    DROP    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_trl_q, out_trl_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  drop_pend_q, drop_pend_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [15:0]           trunc_cnt_q, trunc_cnt_d;

  logic                  out_free;
  logic                  consume;
  logic                  in_ready;
  logic                  accept;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic [DATA_WIDTH-1:0] trailer_word;

  assign out_free = ~out_valid_q | ~Full;
  assign consume  = out_valid_q & ~Full;
  assign cnt_inc  = cnt_q + CNT_WIDTH'(1);

  always_comb begin
    trailer_word                 = '0;
    trailer_word[DATA_WIDTH-1]   = err_q;
    trailer_word[CNT_WIDTH-1:0]  = cnt_q;
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE, BODY: in_ready = out_free;
      TRAILER:    in_ready = 1'b0;
      DROP:       in_ready = 1'b1;
      default:    in_ready = 1'b0;
    endcase
  end

  assign accept = InValid & in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = consume ? 1'b0 : out_valid_q;
    out_data_d  = out_data_q;
    out_trl_d   = out_trl_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    drop_pend_d = drop_pend_q;
    frame_cnt_d = frame_cnt_q;
    trunc_cnt_d = trunc_cnt_q;

    // The err bit of a trailer word is read back from the register itself so
    // the counters track exactly what the FIFO received.
    if (consume && out_trl_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (out_data_q[DATA_WIDTH-1]) trunc_cnt_d = trunc_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = InData;
          out_trl_d   = 1'b0;
          cnt_d       = CNT_WIDTH'(1);
          err_d       = 1'b0;
          if (InLast) begin
            state_d = TRAILER;
          end else if (MAX_CNT == CNT_WIDTH'(1)) begin
            err_d       = 1'b1;
            drop_pend_d = 1'b1;
            state_d     = TRAILER;
          end else begin
            state_d = BODY;
          end
        end
      end
      BODY: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = InData;
          out_trl_d   = 1'b0;
          cnt_d       = cnt_inc;
          if (InLast) begin
            state_d = TRAILER;
          end else if (cnt_inc == MAX_CNT) begin
            err_d       = 1'b1;
            drop_pend_d = 1'b1;
            state_d     = TRAILER;
          end
        end
      end
      TRAILER: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = trailer_word;
          out_trl_d   = 1'b1;
          drop_pend_d = 1'b0;
          state_d     = drop_pend_q ? DROP : IDLE;
        end
      end
      DROP: begin
        if (accept && InLast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Wclk) begin
    if (!Wrstb) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_trl_q   <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      drop_pend_q <= 1'b0;
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_trl_q   <= out_trl_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      drop_pend_q <= drop_pend_d;
      frame_cnt_q <= frame_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign InReady  = in_ready;
  assign Wen      = out_valid_q;
  assign WrData   = out_data_q;
  assign FrameCnt = frame_cnt_q;
  assign TruncCnt = trunc_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_framer.sv
`default_nettype none
// ============================================================================
// tb_fifo_wr_framer : directed bench for fifo_wr_framer with a FIFO capture log.
// Revision 1.0
// ============================================================================
module tb_fifo_wr_framer;

  logic        Wclk = 1'b0;
  logic        Wrstb = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [7:0]  InData = 8'h00;
  logic        InLast = 1'b0;
  logic        Full = 1'b0;
  logic        Wen;
  logic [7:0]  WrData;
  logic [15:0] FrameCnt;
  logic [15:0] TruncCnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] fifo_q[$];

  fifo_wr_framer #(.DATA_WIDTH(8), .MAX_BEATS(16)) dut (
    .Wclk(Wclk), .Wrstb(Wrstb), .InValid(InValid), .InReady(InReady),
    .InData(InData), .InLast(InLast), .Full(Full), .Wen(Wen),
    .WrData(WrData), .FrameCnt(FrameCnt), .TruncCnt(TruncCnt)
  );

  always #5 Wclk = ~Wclk;

  // Stands in for the FIFO: records every word it takes.
  always @(posedge Wclk) begin
    if (Wrstb && Wen && !Full) fifo_q.push_back(WrData);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Wclk);
    Wrstb = 1'b0; InValid = 1'b0; InLast = 1'b0; Full = 1'b0;
    repeat (2) @(negedge Wclk);
    Wrstb = 1'b1;
    fifo_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge Wclk);
    InValid = 1'b1; InData = d; InLast = l;
    #1;
    while (!InReady && n < 50) begin
      @(negedge Wclk); #1; n++;
    end
    if (!InReady) begin
      checks++; errors++;
      $display("FAIL send_timeout observed=InReady 0 expected=1");
    end
    @(posedge Wclk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge Wclk);
    InValid = 1'b0; InLast = 1'b0;
    while (Wen && n < 100) begin
      @(negedge Wclk); n++;
    end
    if (Wen) begin
      checks++; errors++;
      $display("FAIL drain_timeout observed=Wen 1 expected=0");
    end
  endtask

  task automatic check_fifo(input string tag, input logic [7:0] exp[$]);
    check({tag, "_len"}, fifo_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < fifo_q.size()) check($sformatf("%s_w%0d", tag, i), fifo_q[i], exp[i]);
    end
  endtask

  initial begin
    logic [7:0] exp[$];

    // Reset state
    do_reset();
    #1;
    check("rst_wen", Wen, 1'b0);
    check("rst_wrdata", WrData, 8'h00);
    check("rst_framecnt", FrameCnt, 16'd0);
    check("rst_trunccnt", TruncCnt, 16'd0);
    check("rst_inready", InReady, 1'b1);

    // 1: basic three-beat frame with one-cycle latency
    send(8'h11, 1'b0);
    @(negedge Wclk);
    check("t1_lat_wen", Wen, 1'b1);
    check("t1_lat_data", WrData, 8'h11);
    InValid = 1'b1; InData = 8'h22; InLast = 1'b0;
    @(posedge Wclk);
    send(8'h33, 1'b1);
    drain();
    exp = '{8'h11, 8'h22, 8'h33, 8'h03};
    check_fifo("t1", exp);
    check("t1_framecnt", FrameCnt, 16'd1);
    check("t1_trunccnt", TruncCnt, 16'd0);

    // 2: Full held for 5 cycles while 0x22 waits in the register
    do_reset();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    @(negedge Wclk);
    Full = 1'b1; InValid = 1'b1; InData = 8'h33; InLast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t2_wen_c%0d", i), Wen, 1'b1);
      check($sformatf("t2_data_c%0d", i), WrData, 8'h22);
      check($sformatf("t2_rdy_c%0d", i), InReady, 1'b0);
      @(negedge Wclk);
    end
    // Full drops while 0x33 is pending: consume and load on the same edge.
    Full = 1'b0;
    #1;
    check("t2_rdy_release", InReady, 1'b1);
    @(posedge Wclk);
    drain();
    exp = '{8'h11, 8'h22, 8'h33, 8'h03};
    check_fifo("t2", exp);
    check("t2_framecnt", FrameCnt, 16'd1);

    // 3: 20-beat frame truncated at 16, remainder dropped
    do_reset();
    for (int i = 1; i <= 20; i++) send(8'(i), (i == 20));
    drain();
    exp.delete();
    for (int i = 1; i <= 16; i++) exp.push_back(8'(i));
    exp.push_back(8'h90);
    check_fifo("t3", exp);
    check("t3_framecnt", FrameCnt, 16'd1);
    check("t3_trunccnt", TruncCnt, 16'd1);

    // 4: back-to-back single-beat frames with InValid held high
    do_reset();
    send(8'hAA, 1'b1);
    @(negedge Wclk);
    InData = 8'hBB; InLast = 1'b1;
    #1;
    check("t4_gap_rdy", InReady, 1'b0);
    @(negedge Wclk);
    #1;
    check("t4_resume_rdy", InReady, 1'b1);
    @(posedge Wclk);
    @(negedge Wclk);
    #1;
    check("t4_gap2_rdy", InReady, 1'b0);
    InValid = 1'b0;
    drain();
    exp = '{8'hAA, 8'h01, 8'hBB, 8'h01};
    check_fifo("t4", exp);
    check("t4_framecnt", FrameCnt, 16'd2);

    // 5: reset mid-frame abandons the frame
    do_reset();
    send(8'h77, 1'b0);
    send(8'h78, 1'b0);
    @(negedge Wclk);
    InValid = 1'b0;
    check("t5_pre_wen", Wen, 1'b1);
    Wrstb = 1'b0;
    @(negedge Wclk);
    Wrstb = 1'b1;
    #1;
    check("t5_rst_wen", Wen, 1'b0);
    check("t5_rst_framecnt", FrameCnt, 16'd0);
    check("t5_rst_rdy", InReady, 1'b1);
    fifo_q.delete();
    send(8'h55, 1'b1);
    drain();
    exp = '{8'h55, 8'h01};
    check_fifo("t5", exp);
    check("t5_framecnt", FrameCnt, 16'd1);

    // 6: exactly 16 beats ending on the 16th is a normal frame
    do_reset();
    for (int i = 1; i <= 16; i++) send(8'(i), (i == 16));
    drain();
    exp.delete();
    for (int i = 1; i <= 16; i++) exp.push_back(8'(i));
    exp.push_back(8'h10);
    check_fifo("t6", exp);
    check("t6_trunccnt", TruncCnt, 16'd0);
    fifo_q.delete();
    send(8'h42, 1'b1);
    drain();
    exp = '{8'h42, 8'h01};
    check_fifo("t6_next", exp);
    check("t6_framecnt", FrameCnt, 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
